// File: rtl/onehot_scan_encoder.sv
// onehot_scan_encoder
// Synchronises and debounces eight one-hot sense lines, encodes the active
// line to a 3-bit index and hands each index out once over valid/ready.
// Multi-hot debounced vectors raise a one-cycle multi_err pulse.
// Optional build macro PRIORITY_ENCODE_EN: multi-hot vectors are encoded to
// their highest set bit and delivered as a normal event (multi_err still
// pulses). Without the macro, multi-hot vectors produce no event.
module onehot_scan_encoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_lines,
  output logic [2:0] code,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       multi_err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, VALID, RELEASE} state_t;

  logic [7:0]       s1_reg, s2_reg, s2_prev_reg, db_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             stable, db_load;
  logic [2:0]       enc_idx;
  logic             db_onehot, db_multi;
  state_t           state_reg, state_next;
  logic [2:0]       code_reg, code_next;
  logic             code_valid_reg, code_valid_next;
  logic             multi_err_reg, multi_err_next;
  logic             busy_reg, busy_next;

  // Two-flop synchroniser plus the previous-sample register for debounce
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg      <= '0;
      s2_reg      <= '0;
      s2_prev_reg <= '0;
    end else begin
      s1_reg      <= in_lines;
      s2_reg      <= s1_reg;
      s2_prev_reg <= s2_reg;
    end
  end

  // Stability counter: restarts on any change, saturates at DEBOUNCE_CYCLES-1.
  // db loads on the edge where the counter reaches its terminal value, so a
  // vector stable from edge 2 lands in db at edge 2+DEBOUNCE_CYCLES.
  always_comb begin
    stable = (s2_reg == s2_prev_reg);
    if (!stable)
      cnt_next = '0;
    else if (cnt_reg == CNT_MAX)
      cnt_next = cnt_reg;
    else
      cnt_next = cnt_reg + 1'b1;
    db_load = stable && (cnt_next == CNT_MAX);
  end

  // Debounce counter and debounced vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      db_reg  <= '0;
    end else begin
      cnt_reg <= cnt_next;
      if (db_load)
        db_reg <= s2_reg;
    end
  end

  // Index of the highest set bit; for a one-hot vector this is the line index
  always_comb begin
    enc_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (db_reg[i])
        enc_idx = 3'(i);
    end
    db_onehot = (db_reg != 8'd0) && ((db_reg & (db_reg - 8'd1)) == 8'd0);
    db_multi  = (db_reg != 8'd0) && !db_onehot;
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      code_reg       <= 3'd0;
      code_valid_reg <= 1'b0;
      multi_err_reg  <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      code_reg       <= code_next;
      code_valid_reg <= code_valid_next;
      multi_err_reg  <= multi_err_next;
      busy_reg       <= busy_next;
    end
  end

  // Next-state logic: one event per press, then wait for full release
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (db_onehot)
          state_next = VALID;
        else if (db_multi) begin
`ifdef PRIORITY_ENCODE_EN
          state_next = VALID;
`else
          state_next = RELEASE;
`endif
        end
      end
      VALID: begin
        if (code_valid_reg && code_ready)
          state_next = RELEASE;
      end
      RELEASE: begin
        if (db_reg == 8'd0)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    code_next       = code_reg;
    code_valid_next = code_valid_reg;
    multi_err_next  = 1'b0;
    busy_next       = (state_next != IDLE);
    case (state_reg)
      IDLE: begin
        if (db_onehot) begin
          code_next       = enc_idx;
          code_valid_next = 1'b1;
        end else if (db_multi) begin
          multi_err_next  = 1'b1;
`ifdef PRIORITY_ENCODE_EN
          code_next       = enc_idx;
          code_valid_next = 1'b1;
`endif
        end
      end
      VALID: begin
        if (code_valid_reg && code_ready)
          code_valid_next = 1'b0;
      end
      default: ;
    endcase
  end

  assign code       = code_reg;
  assign code_valid = code_valid_reg;
  assign multi_err  = multi_err_reg;
  assign busy       = busy_reg;

endmodule
